// File: rtl/rr_dist_pkg.sv
// Shared types and helpers for the two-channel round-robin distributor.
// Channel index type plus the "other channel" helper used for pointer rotation.
package rr_dist_pkg;

    localparam int N_CH = 2;

    typedef logic chan_idx_t;

    function automatic chan_idx_t next_chan(input chan_idx_t c);
        return ~c;
    endfunction

endpackage

// File: rtl/rr_dist_slot.sv
// One-entry output register for a single distributor channel.
// Latency: loaded word is visible the cycle after the load edge.
// Backpressure: holds data while valid && !ready; a draining slot may be reloaded on the same edge.
module rr_dist_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         can_accept
);

    assign can_accept = !valid || ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            // A load wins over a drain so the slot stays full with the new word.
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/round_robin_distributor_to_2.sv
// Splits one valid/ready stream across two registered output channels in round-robin order.
// Latency: 1 cycle (word accepted at edge k is visible in cycle k+1); 1 word/cycle when both sinks ready.
// Backpressure: up_ready follows the owed channel; RR_DISTRIBUTOR_SKIP_BUSY_EN lets a busy channel be skipped.
module round_robin_distributor_to_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic [1:0]   down_valid,
    input  logic [1:0]   down_ready,
    output logic [W-1:0] down_data0,
    output logic [W-1:0] down_data1
);
    import rr_dist_pkg::*;

    chan_idx_t        ptr;
    chan_idx_t        target;
    logic [N_CH-1:0]  can_accept;
    logic [N_CH-1:0]  load;
    logic             transfer;

    always_comb begin
        target   = ptr;
        up_ready = can_accept[ptr];
`ifdef RR_DISTRIBUTOR_SKIP_BUSY_EN
        // Work-conserving: fall through to the other channel when the owed one is blocked.
        if (!can_accept[ptr]) begin
            target = next_chan(ptr);
        end
        up_ready = can_accept[0] || can_accept[1];
`endif
    end

    assign transfer = up_valid && up_ready;
    assign load[0]  = transfer && (target == 1'b0);
    assign load[1]  = transfer && (target == 1'b1);

    // The channel just served becomes lowest priority for the next word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (transfer) begin
            ptr <= next_chan(target);
        end
    end

    rr_dist_slot #(.W(W)) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load[0]),
        .load_data  (up_data),
        .ready      (down_ready[0]),
        .valid      (down_valid[0]),
        .data       (down_data0),
        .can_accept (can_accept[0])
    );

    rr_dist_slot #(.W(W)) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load[1]),
        .load_data  (up_data),
        .ready      (down_ready[1]),
        .valid      (down_valid[1]),
        .data       (down_data1),
        .can_accept (can_accept[1])
    );

endmodule

// File: doc/round_robin_distributor_to_2.md
Name: round_robin_distributor_to_2

Overview:
- Splits one valid/ready input stream across two output channels in strict round-robin order: word 0 to ch0, word 1 to ch1, word 2 to ch0, and so on.
- It is the fan-out counterpart of the 2-request round-robin arbiter. A distributor at the split point and an arbiter at the merge point together preserve word order across two parallel workers.
- Each channel has a one-entry output register, so every output is registered.

Parameters:
- W, 8, data width in bits.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- up_valid  input  1  input word present.
- up_data  input  W  input word.
- up_ready  output  1  distributor accepts the word this cycle.
- down_valid  output  2  bit i: channel i holds a word.
- down_ready  input  2  bit i: consumer i accepts this cycle.
- down_data0  output  W  channel 0 word.
- down_data1  output  W  channel 1 word.

Behaviour:
- State:
  - ptr (1 bit): channel owed the next word.
  - buf_valid[1:0] and buf_data0/buf_data1.
  - down_valid = buf_valid; down_dataN = buf_dataN.
- Reset (rst=0, asynchronous): ptr=0, buf_valid=00, buf_data0/buf_data1 = 0. Outputs drop immediately, mid-cycle, regardless of clk. After release: down_valid=00, up_ready=1.
- can_accept[i] = !buf_valid[i] || down_ready[i]. A full slot being drained this cycle can be reloaded in the same cycle.
- up_ready = can_accept[ptr]. This is combinational from down_ready and ptr. up_ready must not depend on up_valid.
- Input transfer = up_valid && up_ready. On a transfer:
  - buf_data[ptr] <= up_data;
  - buf_valid[ptr] <= 1;
  - ptr <= ~ptr.
- Output transfer on channel i = buf_valid[i] && down_ready[i]. It clears buf_valid[i] unless the same cycle is an input transfer into i, in which case buf_valid[i] stays 1 with new data.
- Latency: a word accepted at edge k appears on down_valid/down_data at edge k, i.e. visible in cycle k+1. Throughput is 1 word/cycle when both consumers are ready.
- Bubbles: ptr advances only on an input transfer. up_valid=0 cycles and stalled cycles leave ptr unchanged.
- Ordering: strict alternation. If the channel owed the next word is full and stalled, the input stalls even when the other channel is empty.
- Data stability: buf_dataN holds while buf_valid[N]=1 and down_ready[N]=0. down_valid[N] never deasserts without a transfer.
- Simultaneous events (both outputs draining, one input loading) are handled independently per channel. No priority is needed, since the input targets exactly one channel.
- up_data is ignored when no transfer occurs.

Optional Feature:
- Macro: RR_DISTRIBUTOR_SKIP_BUSY_EN.
- Defined (work-conserving mode):
  - target = ptr if can_accept[ptr], else ~ptr if can_accept[~ptr].
  - up_ready = can_accept[0] || can_accept[1].
  - On a transfer the word goes to target and ptr <= ~target, mirroring the arbiter's "last served gets lowest priority" rule.
- Undefined: strict alternation as specified in Behaviour.
- In both modes, reset and latency are identical.

Decomposition:
- Package rr_dist_pkg:
  - localparam N_CH = 2;
  - typedef logic chan_idx_t (channel index / ptr type);
  - function next_chan(chan_idx_t) returning the other channel.
- Sub-module rr_dist_slot:
  - one-entry register with load, drain and reload-on-drain logic;
  - parameter W; asynchronous active-low rst;
  - instantiated twice.
- The top level holds ptr, up_ready and target selection.

Test Plan:
- Reset: hold rst=0 while up_valid=1 and down_ready=11 -> down_valid=00, no load. Release -> up_ready=1 and the first word 0xA1 lands in ch0.
- Streaming: down_ready=11, words 0x01,0x02,0x03,0x04 on consecutive cycles -> ch0 gets 0x01 then 0x03, ch1 gets 0x02 then 0x04, each one cycle after acceptance. up_ready stays 1 throughout.
- Backpressure: down_ready=00, send 0x10 and 0x11 -> down_valid=11 and up_ready=0 with 0x12 pending. Raise down_ready[0] for one cycle -> 0x10 drains and 0x12 loads into ch0 that same edge; down_valid stays 11.
- Strict stall:
  - Setup: ch0 full and stalled, ch1 empty, ptr=0.
  - Macro undefined -> up_ready=0 until down_ready[0]=1.
  - Macro defined -> the word goes to ch1 and ptr becomes 0.
- Bubbles: up_valid pattern 1,0,1,1 with data 0x20,x,0x21,0x22 and down_ready=11 -> ch0=0x20, ch1=0x21, ch0=0x22. ptr unchanged on the idle cycle.
- Mid-operation reset: with down_valid=11, assert rst=0 asynchronously between edges -> down_valid=00 before the next edge. After release, the next word goes to ch0.
